// File: rtl/sgdmac_rd_arbiter.sv
// sgdmac_rd_arbiter: round-robin arbiter that funnels N_CH read-engine AR
// requests onto one AXI read master, one burst outstanding at a time.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   m_ar*_i / m_arready_o      per-channel AR request side (fields packed per channel)
//   m_rvalid_o / m_rready_i    per-channel R handshake
//   m_rdata_o/m_rresp_o/m_rlast_o  R payload broadcast to every channel
//   ar*_o / arready_i          AXI AR master channel (arid = owning channel)
//   r*_i / rready_o            AXI R channel
//   grant_o, busy_o, err_o     owning channel, not-idle flag, sticky RID-mismatch
module sgdmac_rd_arbiter #(
  parameter int unsigned N_CH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_CH-1:0]     m_arvalid_i,
  input  logic [32*N_CH-1:0]  m_araddr_i,
  input  logic [4*N_CH-1:0]   m_arlen_i,
  input  logic [3*N_CH-1:0]   m_arsize_i,
  input  logic [2*N_CH-1:0]   m_arburst_i,
  output logic [N_CH-1:0]     m_arready_o,
  output logic [N_CH-1:0]     m_rvalid_o,
  input  logic [N_CH-1:0]     m_rready_i,
  output logic [31:0]         m_rdata_o,
  output logic [1:0]          m_rresp_o,
  output logic                m_rlast_o,
  output logic [3:0]          arid_o,
  output logic [31:0]         araddr_o,
  output logic [3:0]          arlen_o,
  output logic [2:0]          arsize_o,
  output logic [1:0]          arburst_o,
  output logic                arvalid_o,
  input  logic                arready_i,
  input  logic [3:0]          rid_i,
  input  logic [31:0]         rdata_i,
  input  logic [1:0]          rresp_i,
  input  logic                rlast_i,
  input  logic                rvalid_i,
  output logic                rready_o,
  output logic [3:0]          grant_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned GW = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;

  state_e        state_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] rr_ptr_q;
  logic          err_q;

  // Round-robin winner: first requester at or above rr_ptr, wrapping.
  logic          win_found;
  logic [GW-1:0] win_idx;
  logic [GW:0]   pos;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pos = {1'b0, rr_ptr_q} + (GW+1)'(i);
      if (pos >= (GW+1)'(N_CH)) pos = pos - (GW+1)'(N_CH);
      for (int unsigned k = 0; k < N_CH; k++) begin
        if (!win_found && m_arvalid_i[k] && (pos == (GW+1)'(k))) begin
          win_found = 1'b1;
          win_idx   = GW'(k);
        end
      end
    end
  end

  // Field mux and one-hot decode of the registered grant.
  logic              sel_arvalid;
  logic              sel_rready;
  logic [31:0]       sel_addr;
  logic [3:0]        sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;
  logic [N_CH-1:0]   gnt_oh;

  always_comb begin
    sel_arvalid = 1'b0;
    sel_rready  = 1'b0;
    sel_addr    = '0;
    sel_len     = '0;
    sel_size    = '0;
    sel_burst   = '0;
    gnt_oh      = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant_q == GW'(k)) begin
        sel_arvalid = m_arvalid_i[k];
        sel_rready  = m_rready_i[k];
        sel_addr    = m_araddr_i[32*k +: 32];
        sel_len     = m_arlen_i[4*k +: 4];
        sel_size    = m_arsize_i[3*k +: 3];
        sel_burst   = m_arburst_i[2*k +: 2];
        gnt_oh[k]   = 1'b1;
      end
    end
  end

  // State, grant, round-robin pointer and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            grant_q <= win_idx;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (sel_arvalid && arready_i) begin
            state_q  <= ST_DATA;
            rr_ptr_q <= (grant_q == GW'(N_CH-1)) ? '0 : grant_q + GW'(1);
          end
        end
        ST_DATA: begin
          // Mismatched beats are still routed; only the flag records them.
          if (rvalid_i && (rid_i != grant_q)) err_q <= 1'b1;
          if (rvalid_i && sel_rready && rlast_i) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign arvalid_o   = (state_q == ST_ADDR) && sel_arvalid;
  assign arid_o      = grant_q;
  assign araddr_o    = sel_addr;
  assign arlen_o     = sel_len;
  assign arsize_o    = sel_size;
  assign arburst_o   = sel_burst;
  assign m_arready_o = ((state_q == ST_ADDR) && arready_i) ? gnt_oh : '0;

  assign rready_o    = (state_q == ST_DATA) && sel_rready;
  assign m_rvalid_o  = ((state_q == ST_DATA) && rvalid_i) ? gnt_oh : '0;
  assign m_rdata_o   = rdata_i;
  assign m_rresp_o   = rresp_i;
  assign m_rlast_o   = rlast_i;

  assign grant_o     = grant_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

endmodule

// File: tb/tb_sgdmac_rd_arbiter.sv
// Directed bench for sgdmac_rd_arbiter with N_CH = 4.
module tb_sgdmac_rd_arbiter;

  localparam int unsigned N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    m_arvalid;
  logic [32*N-1:0] m_araddr;
  logic [4*N-1:0]  m_arlen;
  logic [3*N-1:0]  m_arsize;
  logic [2*N-1:0]  m_arburst;
  logic [N-1:0]    m_arready;
  logic [N-1:0]    m_rvalid;
  logic [N-1:0]    m_rready;
  logic [31:0]     m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic [3:0]      arid_o;
  logic [31:0]     araddr_o;
  logic [3:0]      arlen_o;
  logic [2:0]      arsize_o;
  logic [1:0]      arburst_o;
  logic            arvalid_o;
  logic            arready_i;
  logic [3:0]      rid_i;
  logic [31:0]     rdata_i;
  logic [1:0]      rresp_i;
  logic            rlast_i;
  logic            rvalid_i;
  logic            rready_o;
  logic [3:0]      grant_o;
  logic            busy_o;
  logic            err_o;

  int n_assert;
  int n_fail;

  sgdmac_rd_arbiter #(.N_CH(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_arvalid_i(m_arvalid), .m_araddr_i(m_araddr), .m_arlen_i(m_arlen),
    .m_arsize_i(m_arsize), .m_arburst_i(m_arburst), .m_arready_o(m_arready),
    .m_rvalid_o(m_rvalid), .m_rready_i(m_rready),
    .m_rdata_o(m_rdata), .m_rresp_o(m_rresp), .m_rlast_o(m_rlast),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .grant_o(grant_o), .busy_o(busy_o), .err_o(err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Step to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs before checking.
  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [31:0] addr, input logic [3:0] len);
    m_araddr[32*k +: 32] = addr;
    m_arlen[4*k +: 4]    = len;
    m_arsize[3*k +: 3]   = 3'd2;
    m_arburst[2*k +: 2]  = 2'd1;
  endtask

  // One single-beat burst from IDLE with requests already presented.
  task automatic rr_burst(input logic [3:0] g);
    tick(); settle();
    chk("rr_grant", grant_o, g);
    chk("rr_arid", arid_o, g);
    chk("rr_arvalid", arvalid_o, 1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0;
    rvalid_i = 1'b1; rlast_i = 1'b1; rid_i = g; rdata_i = 32'hA0 + 32'(g);
    settle();
    chk("rr_rvalid", m_rvalid, 4'b0001 << g);
    tick();
    rvalid_i = 1'b0; rlast_i = 1'b0;
    settle();
    chk("rr_idle", busy_o, 0);
  endtask

  initial begin
    int b;
    logic rdy;
    n_assert = 0; n_fail = 0;
    rst_n = 1'b0;
    m_arvalid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_rready = '0; arready_i = 1'b0; rid_i = '0; rdata_i = '0; rresp_i = '0;
    rlast_i = 1'b0; rvalid_i = 1'b0;

    // Reset state
    tick(); tick(); settle();
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_rready", rready_o, 0);
    chk("rst_m_arready", m_arready, 0);
    chk("rst_m_rvalid", m_rvalid, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_err", err_o, 0);

    // Single request from ch2, 4-beat burst
    rst_n = 1'b1;
    tick();
    set_ch(2, 32'h1000, 4'd3);
    m_arvalid = 4'b0100;
    settle();
    chk("single_idle_arvalid", arvalid_o, 0);
    tick(); settle();
    chk("single_arvalid", arvalid_o, 1);
    chk("single_arid", arid_o, 2);
    chk("single_araddr", araddr_o, 32'h1000);
    chk("single_arlen", arlen_o, 3);
    chk("single_busy", busy_o, 1);
    chk("single_m_arready_lo", m_arready, 0);
    arready_i = 1'b1;
    settle();
    chk("single_m_arready", m_arready, 4'b0100);
    tick();
    arready_i = 1'b0; m_arvalid = '0; m_rready = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      rvalid_i = 1'b1; rid_i = 4'd2; rdata_i = 32'hD000 + 32'(k); rlast_i = (k == 3);
      settle();
      chk("single_data_arvalid", arvalid_o, 0);
      chk("single_m_rvalid", m_rvalid, 4'b0100);
      chk("single_rready", rready_o, 1);
      chk("single_rdata", m_rdata, 32'hD000 + 32'(k));
      tick();
    end
    rvalid_i = 1'b0; rlast_i = 1'b0;
    settle();
    chk("single_done_busy", busy_o, 0);
    chk("single_done_err", err_o, 0);

    // Stray beat while idle
    rvalid_i = 1'b1; rid_i = 4'd0; m_rready = 4'b1111;
    settle();
    chk("stray_rready", rready_o, 0);
    chk("stray_m_rvalid", m_rvalid, 0);
    tick(); settle();
    chk("stray_err", err_o, 0);
    rvalid_i = 1'b0;

    // Round robin after a fresh reset
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) set_ch(k, 32'h100 * 32'(k), 4'd0);
    m_arvalid = 4'b1111; m_rready = 4'b1111;
    rr_burst(4'd0);
    rr_burst(4'd1);
    rr_burst(4'd2);
    rr_burst(4'd3);
    rr_burst(4'd0);
    m_arvalid = '0;

    // Backpressure: ch1 wins over ch3, AR stalled, R ready toggling
    set_ch(1, 32'h2000, 4'd2);
    set_ch(3, 32'h3000, 4'd5);
    m_arvalid = 4'b1010;
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      chk("bp_arvalid", arvalid_o, 1);
      chk("bp_araddr", araddr_o, 32'h2000);
      chk("bp_arlen", arlen_o, 2);
      chk("bp_grant", grant_o, 1);
      chk("bp_m_arready", m_arready, 0);
      tick();
    end
    arready_i = 1'b1;
    settle();
    chk("bp_m_arready_hs", m_arready, 4'b0010);
    tick();
    arready_i = 1'b0; m_arvalid = 4'b1000;
    b = 0;
    for (int c = 0; c < 8 && b < 3; c++) begin
      rdy = ((c % 2) == 1);
      m_rready = {3'b111, 1'b1}; m_rready[1] = rdy;
      rvalid_i = 1'b1; rid_i = 4'd1; rdata_i = 32'h2000_0000 + 32'(b);
      rlast_i = (b == 2); rresp_i = 2'b10;
      settle();
      chk("bp_rready", rready_o, rdy);
      chk("bp_m_rvalid", m_rvalid, 4'b0010);
      chk("bp_rdata", m_rdata, 32'h2000_0000 + 32'(b));
      chk("bp_rresp", m_rresp, 2'b10);
      chk("bp_hold_grant", grant_o, 1);
      chk("bp_busy", busy_o, 1);
      tick();
      if (rdy) b++;
    end
    rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; m_arvalid = '0;
    settle();
    chk("bp_done_busy", busy_o, 0);
    chk("bp_rresp_no_err", err_o, 0);

    // RID mismatch on beat 2 of a ch1 burst
    m_arvalid = 4'b0010;
    tick(); settle();
    chk("rid_grant", grant_o, 1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0; m_arvalid = '0; m_rready = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      rvalid_i = 1'b1; rid_i = (k == 1) ? 4'd3 : 4'd1; rlast_i = (k == 2);
      rdata_i = 32'hE000 + 32'(k);
      settle();
      chk("rid_err_track", err_o, (k >= 2) ? 1 : 0);
      chk("rid_m_rvalid", m_rvalid, 4'b0010);
      tick();
    end
    rvalid_i = 1'b0; rlast_i = 1'b0;
    settle();
    chk("rid_err_set", err_o, 1);
    chk("rid_done_busy", busy_o, 0);
    tick(); tick(); tick(); settle();
    chk("rid_err_sticky", err_o, 1);

    // Reset during DATA after one beat of an arlen 7 burst on ch2
    set_ch(2, 32'h4000, 4'd7);
    m_arvalid = 4'b0100;
    tick(); settle();
    chk("mid_grant", grant_o, 2);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0; m_arvalid = '0; m_rready = 4'b0100;
    rvalid_i = 1'b1; rid_i = 4'd2; rlast_i = 1'b0; rdata_i = 32'h4444;
    settle();
    chk("mid_m_rvalid", m_rvalid, 4'b0100);
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    settle();
    chk("mid_busy", busy_o, 0);
    chk("mid_rready", rready_o, 0);
    chk("mid_grant_rst", grant_o, 0);
    chk("mid_err_rst", err_o, 0);
    chk("mid_m_rvalid_rst", m_rvalid, 0);
    chk("mid_arvalid_rst", arvalid_o, 0);
    rvalid_i = 1'b0;
    m_arvalid = 4'b1001;
    tick(); settle();
    chk("mid_rrptr_grant", grant_o, 0);
    chk("mid_rrptr_arid", arid_o, 0);
    m_arvalid = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sgdmac_rd_arbiter.md
SGDMAC_RD_ARBITER -- requirements
Module: sgdmac_rd_arbiter

Interface
REQ-001 Parameter: N_CH, default 4, number of read-engine requesters (legal 2..16).
REQ-002 Port: clk  input  1  clock; all logic on rising edge.
REQ-003 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 Port: m_arvalid_i  input  N_CH  per-channel AR valid.
REQ-005 Port: m_araddr_i  input  32*N_CH  per-channel AR address; channel k at bits [32k+31:32k].
REQ-006 Port: m_arlen_i  input  4*N_CH  per-channel burst length.
REQ-007 Port: m_arsize_i  input  3*N_CH  per-channel burst size.
REQ-008 Port: m_arburst_i  input  2*N_CH  per-channel burst type.
REQ-009 Port: m_arready_o  output  N_CH  per-channel AR ready.
REQ-010 Port: m_rvalid_o  output  N_CH  per-channel R valid.
REQ-011 Port: m_rready_i  input  N_CH  per-channel R ready.
REQ-012 Port: m_rdata_o, m_rresp_o, m_rlast_o  output  32/2/1  shared R payload broadcast to all channels.
REQ-013 Port: arid_o, araddr_o, arlen_o, arsize_o, arburst_o, arvalid_o  output  4/32/4/3/2/1  AXI AR master channel.
REQ-014 Port: arready_i  input  1  AXI AR ready.
REQ-015 Port: rid_i, rdata_i, rresp_i, rlast_i, rvalid_i  input  4/32/2/1/1  AXI R channel.
REQ-016 Port: rready_o  output  1  AXI R ready.
REQ-017 Port: grant_o  output  4  index of currently owning channel.
REQ-018 Port: busy_o  output  1  high when state is not IDLE.
REQ-019 Port: err_o  output  1  sticky RID-mismatch error.

Function
REQ-020 FSM SHALL have states IDLE, ADDR, DATA; one AXI burst outstanding at a time.
REQ-021 IDLE: if any m_arvalid_i bit set, winner = first set bit searching from rr_ptr upward, wrapping mod N_CH; grant register <= winner; next state ADDR.
REQ-022 Latency: request sampled in cycle N -> arvalid_o high in cycle N+1.
REQ-023 ADDR: arvalid_o = m_arvalid_i[grant]; araddr/arlen/arsize/arburst = granted channel's fields (combinational mux on registered grant); arid_o = grant zero-extended.
REQ-024 ADDR: m_arready_o[grant] = arready_i; all other m_arready_o bits 0 in every state.
REQ-025 ADDR: on arvalid_o & arready_i -> DATA, rr_ptr <= (grant+1) mod N_CH; if granted channel drops arvalid, remain in ADDR.
REQ-026 DATA: m_rvalid_o[grant] = rvalid_i, rready_o = m_rready_i[grant]; other m_rvalid_o bits 0.
REQ-027 DATA: on rvalid_i & rready_o & rlast_i -> IDLE; new arbitration starts the following cycle (min 1 idle cycle between bursts).
REQ-028 m_rdata_o/m_rresp_o/m_rlast_o SHALL equal rdata_i/rresp_i/rlast_i unconditionally.
REQ-029 IDLE and ADDR: rready_o = 0, all m_rvalid_o = 0; stray R beats are not accepted.
REQ-030 DATA: rvalid_i high with rid_i != arid_o sets err_o; err_o clears only on reset; beat still routed.
REQ-031 rresp_i non-zero SHALL pass through unmodified and SHALL NOT affect FSM or err_o.
REQ-032 Grant SHALL NOT change between arbitration and the rlast handshake, regardless of other requests.
REQ-033 Fairness: with all channels requesting continuously, each channel granted once per N_CH bursts.

Reset
REQ-034 While rst_n = 0 at a clk edge: state <= IDLE, grant <= 0, rr_ptr <= 0, err_o <= 0.
REQ-035 Reset values: arvalid_o=0, rready_o=0, m_arready_o=0, m_rvalid_o=0, busy_o=0, grant_o=0.
REQ-036 Reset mid-burst SHALL abandon the burst; no partial state retained.

Verification
REQ-037 Single: ch2 requests addr 0x1000 arlen 3 -> next cycle arvalid_o=1, arid_o=2, araddr_o=0x1000; 4 beats routed only to m_rvalid_o[2]; busy_o low after rlast.
REQ-038 Round-robin: ch0..ch3 request continuously -> grant order 0,1,2,3,0.
REQ-039 Backpressure: arready_i low 5 cycles in ADDR, m_rready_i[grant] toggling in DATA -> fields stable, no beat lost or duplicated, grant held.
REQ-040 RID mismatch: grant=1, rid_i=3 on beat 2 -> err_o=1 from next cycle, stays 1 until reset.
REQ-041 Stray beat: rvalid_i=1 in IDLE -> rready_o=0, all m_rvalid_o=0, err_o unchanged.
REQ-042 Reset in DATA after beat 1 of arlen 7 -> next cycle busy_o=0, rready_o=0, grant_o=0, rr_ptr=0.
